// File: rtl/spectrum_line_feeder.sv
// Ping-pong FFT magnitude store feeding scaled, clamped bar lengths to the LCD
// spectrum renderer, one bar per line request, all in the LCD clock domain.
module spectrum_line_feeder #(
   parameter int LINE_NUM   = 64,
   parameter int H_LCD_DISP = 800,
   parameter int MAG_SHIFT  = 4
) (
   input  logic        lcd_clk,
   input  logic        sys_rst_n,
   input  logic        fft_valid,
   input  logic [15:0] fft_mag,
   input  logic        fft_last,
   input  logic        data_req,
   input  logic        wr_over,
   output logic [6:0]  line_cnt,
   output logic [15:0] line_length,
   output logic        frame_drop
);

   localparam logic [6:0]  LAST_LINE = 7'(LINE_NUM - 1);
   localparam logic [6:0]  LINE_END  = 7'(LINE_NUM);
   localparam logic [15:0] MAX_LEN   = 16'(H_LCD_DISP - 1);

   logic [15:0] mem_q [2][LINE_NUM];
   logic [6:0]  waddr_q, waddr_d;
   logic [6:0]  line_cnt_q, line_cnt_d;
   logic        pending_q, pending_d;
   logic        wbank_q, wbank_d;
   logic        frame_drop_q, frame_drop_d;
   logic [15:0] line_length_q, line_length_d;
   logic [15:0] rd_bin;
   logic        rbank;
   logic        wr_en;
   logic        frame_end;
   logic        swap;

   function automatic logic [15:0] clamp_len(input logic [15:0] mag);
      logic [15:0] m;
      m = mag >> MAG_SHIFT;
      return (m > MAX_LEN) ? MAX_LEN : m;
   endfunction

   always_comb begin
      rbank     = ~wbank_q;
      wr_en     = fft_valid && (waddr_q < LINE_END);
      frame_end = fft_valid && fft_last;
      swap      = wr_over && (line_cnt_q == LAST_LINE) && (pending_q || frame_end);

      rd_bin = '0;
      for (int i = 0; i < LINE_NUM; i++) begin
         if (line_cnt_q == 7'(i)) rd_bin = mem_q[rbank][i];
      end

      waddr_d = waddr_q;
      if (fft_valid && (waddr_q != LINE_END)) waddr_d = waddr_q + 7'd1;
      if (frame_end || swap) waddr_d = '0;

      // A swap retires the pending frame even if it completes in this same cycle.
      pending_d = pending_q;
      if (frame_end) pending_d = 1'b1;
      if (swap) pending_d = 1'b0;

      frame_drop_d = frame_end && pending_q;
      wbank_d      = swap ? ~wbank_q : wbank_q;

      line_cnt_d = line_cnt_q;
      if (wr_over) line_cnt_d = (line_cnt_q == LAST_LINE) ? 7'd0 : line_cnt_q + 7'd1;

      line_length_d = data_req ? clamp_len(rd_bin) : line_length_q;
   end

   // Writes target the pre-swap bank, so a final bin coinciding with a swap lands
   // in the bank that is about to be displayed.
   always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < LINE_NUM; i++) mem_q[b][i] <= '0;
         end
      end else begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < LINE_NUM; i++) begin
               if (wr_en && (wbank_q == 1'(b)) && (waddr_q == 7'(i))) mem_q[b][i] <= fft_mag;
            end
         end
      end
   end

   always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         waddr_q       <= '0;
         line_cnt_q    <= '0;
         pending_q     <= 1'b0;
         wbank_q       <= 1'b0;
         frame_drop_q  <= 1'b0;
         line_length_q <= '0;
      end else begin
         waddr_q       <= waddr_d;
         line_cnt_q    <= line_cnt_d;
         pending_q     <= pending_d;
         wbank_q       <= wbank_d;
         frame_drop_q  <= frame_drop_d;
         line_length_q <= line_length_d;
      end
   end

   assign line_cnt    = line_cnt_q;
   assign line_length = line_length_q;
   assign frame_drop  = frame_drop_q;

endmodule

// File: tb/tb_spectrum_line_feeder.sv
// Scoreboard bench for spectrum_line_feeder: stimulus queues expected values,
// a negedge monitor pops and compares them as the DUT produces results.
module tb_spectrum_line_feeder;

   logic        lcd_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        fft_valid = 1'b0;
   logic [15:0] fft_mag = '0;
   logic        fft_last = 1'b0;
   logic        data_req = 1'b0;
   logic        wr_over = 1'b0;
   logic [6:0]  line_cnt;
   logic [15:0] line_length;
   logic        frame_drop;

   spectrum_line_feeder #(.LINE_NUM(64), .H_LCD_DISP(800), .MAG_SHIFT(4)) dut (
      .lcd_clk(lcd_clk), .sys_rst_n(sys_rst_n), .fft_valid(fft_valid), .fft_mag(fft_mag),
      .fft_last(fft_last), .data_req(data_req), .wr_over(wr_over), .line_cnt(line_cnt),
      .line_length(line_length), .frame_drop(frame_drop)
   );

   always #5 lcd_clk = ~lcd_clk;

   typedef struct {int kind; int exp;} probe_t;

   int     sb[$];
   probe_t pq[$];
   int     n_chk = 0;
   int     n_fail = 0;
   int     drop_cnt = 0;
   bit     req_seen = 1'b0;
   int     exp_scr[64];

   always @(posedge lcd_clk) req_seen <= data_req;

   always @(negedge lcd_clk) begin
      int     e;
      int     act;
      probe_t p;
      string  nm;
      if (frame_drop === 1'b1) drop_cnt++;
      if (req_seen) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL line_length: got %0d but no expected value queued", line_length);
         end else begin
            e = sb.pop_front();
            if (int'(line_length) !== e) begin
               n_fail++;
               $display("FAIL line_length (line_cnt %0d): got %0d expected %0d", line_cnt, line_length, e);
            end
         end
      end
      while (pq.size() > 0) begin
         p = pq.pop_front();
         case (p.kind)
            0: begin act = int'(line_cnt);    nm = "line_cnt";    end
            1: begin act = int'(line_length); nm = "line_length"; end
            2: begin act = int'(frame_drop);  nm = "frame_drop";  end
            3: begin act = drop_cnt;          nm = "drop_count";  end
            default: begin act = sb.size();   nm = "sb_leftover"; end
         endcase
         n_chk++;
         if (act !== p.exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, p.exp);
         end
      end
   end

   task automatic tick();
      @(posedge lcd_clk);
      #1;
   endtask

   task automatic probe(input int kind, input int exp);
      probe_t p;
      p.kind = kind;
      p.exp  = exp;
      pq.push_back(p);
   endtask

   task automatic wr_bin(input logic [15:0] mag, input bit last);
      fft_valid = 1'b1;
      fft_mag   = mag;
      fft_last  = last;
      tick();
      fft_valid = 1'b0;
      fft_last  = 1'b0;
   endtask

   task automatic line_pair(input int exp, input bit adv, input bit with_last, input logic [15:0] mag);
      data_req = 1'b1;
      wr_over  = adv;
      if (with_last) begin
         fft_valid = 1'b1;
         fft_mag   = mag;
         fft_last  = 1'b1;
      end
      sb.push_back(exp);
      tick();
      data_req  = 1'b0;
      wr_over   = 1'b0;
      fft_valid = 1'b0;
      fft_last  = 1'b0;
      tick();
   endtask

   task automatic run_screen();
      for (int k = 0; k < 64; k++) line_pair(exp_scr[k], 1'b1, 1'b0, 16'd0);
   endtask

   initial begin
      repeat (3) tick();
      probe(0, 0); probe(1, 0); probe(2, 0);
      tick();
      sys_rst_n = 1'b1;
      tick();

      // Frame load: bin k = k*256, first screen still shows the empty bank
      for (int k = 0; k < 64; k++) wr_bin(16'(k * 256), k == 63);
      for (int k = 0; k < 64; k++) exp_scr[k] = 0;
      run_screen();
      probe(0, 0);

      // Clamp frame written while the loaded frame is displayed
      wr_bin(16'hFFFF, 1'b0);
      wr_bin(16'd12784, 1'b0);
      wr_bin(16'd12768, 1'b1);
      for (int k = 0; k < 64; k++) exp_scr[k] = (k * 16 > 799) ? 799 : k * 16;
      run_screen();
      probe(0, 0);

      // Overrun: two full frames before the screen ends
      for (int k = 0; k < 64; k++) wr_bin(16'd100, k == 63);
      probe(3, 0);
      for (int k = 0; k < 64; k++) wr_bin(16'd200, k == 63);
      probe(3, 1);
      for (int k = 0; k < 64; k++) exp_scr[k] = 0;
      exp_scr[0] = 799; exp_scr[1] = 799; exp_scr[2] = 798;
      run_screen();

      // Excess bins, then a one-bin frame that must land at address 0
      for (int k = 0; k < 100; k++) wr_bin(16'((k + 1) * 16), k == 99);
      wr_bin(16'd5000, 1'b1);
      probe(3, 2);
      for (int k = 0; k < 64; k++) exp_scr[k] = 12;
      run_screen();

      for (int k = 0; k < 64; k++) exp_scr[k] = (k == 0) ? 312 : k + 1;
      run_screen();

      // Coincidence: final bin arrives with the last wr_over of a screen
      for (int k = 0; k < 63; k++) wr_bin(16'(k * 32), 1'b0);
      for (int k = 0; k < 63; k++) line_pair(exp_scr[k], 1'b1, 1'b0, 16'd0);
      line_pair(exp_scr[63], 1'b1, 1'b1, 16'd4000);
      probe(0, 0);
      probe(3, 2);
      for (int k = 0; k < 64; k++) exp_scr[k] = (k < 63) ? 2 * k : 250;
      run_screen();

      // Reset in the middle of a line sequence and a frame write
      line_pair(0, 1'b1, 1'b0, 16'd0);
      line_pair(2, 1'b1, 1'b0, 16'd0);
      line_pair(4, 1'b1, 1'b0, 16'd0);
      probe(0, 3);
      probe(1, 4);
      fft_valid = 1'b1;
      fft_mag   = 16'd777;
      tick();
      sys_rst_n = 1'b0;
      fft_valid = 1'b0;
      #1;
      probe(0, 0); probe(1, 0); probe(2, 0);
      tick();
      tick();
      sys_rst_n = 1'b1;
      tick();
      line_pair(0, 1'b0, 1'b0, 16'd0);
      probe(0, 0);

      repeat (3) tick();
      probe(4, 0);
      repeat (2) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/spectrum_line_feeder.md
# spectrum_line_feeder

Supplies per-line spectrum lengths to the LCD spectrum renderer. FFT magnitude frames are captured into a ping-pong bin store. The block answers the renderer's per-line data requests with a scaled, clamped bar length, and advances the line index on each line-complete pulse. It sits between the FFT magnitude stage and the LCD display path, entirely in the LCD clock domain.

## Interface
Parameters:
- LINE_NUM, 64: bars per screen; legal range 1..78 (bar row = line_cnt*6+8 must stay < 480).
- H_LCD_DISP, 800: LCD horizontal resolution; bar lengths clamp to H_LCD_DISP-1.
- MAG_SHIFT, 4: right shift applied to the magnitude before clamping.

Ports:
- lcd_clk  in  1  LCD driver clock; the only clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- fft_valid  in  1  magnitude sample valid (one bin per cycle).
- fft_mag  in  16  unsigned bin magnitude.
- fft_last  in  1  qualifies the final bin of a frame (only with fft_valid).
- data_req  in  1  single-cycle request for the length of bar line_cnt.
- wr_over  in  1  single-cycle pulse: bar line_cnt fully drawn.
- line_cnt  out  7  current bar index, 0..LINE_NUM-1.
- line_length  out  16  bar length in pixels for line_cnt.
- frame_drop  out  1  single-cycle pulse: a completed frame was overwritten before it was displayed.

## Operation
- Store: two banks (A, B), each LINE_NUM x 16 bits, zeroed by reset. wbank selects the write bank (reset A); the read bank is always the other one.
- Write side:
  - waddr (reset 0) increments on every fft_valid and saturates at LINE_NUM.
  - When waddr < LINE_NUM, fft_mag is written to wbank[waddr]; bins at or beyond LINE_NUM are discarded.
  - On fft_valid&&fft_last, waddr returns to 0 and pending is set (reset 0).
  - If pending was already 1 at that moment, frame_drop pulses. The newer frame overwrites in place, so the latest frame wins.
- Line counter:
  - line_cnt resets to 0.
  - On wr_over it increments; it wraps from LINE_NUM-1 to 0.
- Bank swap: occurs when wr_over arrives with line_cnt==LINE_NUM-1 and either pending==1 or fft_valid&&fft_last in the same cycle. On swap, wbank toggles, pending clears, and waddr is forced to 0. With no pending frame, the current read bank is redisplayed.
- Read side:
  - On data_req, read bin rbank[line_cnt] using the line_cnt value before any same-cycle update.
  - Compute m = fft_mag_stored >> MAG_SHIFT.
  - line_length <= (m > H_LCD_DISP-1) ? H_LCD_DISP-1 : m.
  - line_length holds until the next data_req.
- Simultaneous events:
  - data_req with wr_over: the read uses the old line_cnt.
  - A write to the bank being swapped in that same cycle completes first, so the final bin is visible after the swap.
- Reset mid-operation clears all state immediately: banks, waddr, pending, wbank, line_cnt, line_length and frame_drop.

## Timing
- Reset values: line_cnt=0, line_length=0, frame_drop=0.
- Read latency: line_length is valid exactly 1 lcd_clk after data_req. The renderer asserts data_req at x=H_LCD_DISP-1 of the preceding row, so the value is stable at x=0 of the bar row.
- line_cnt updates on the edge after wr_over.
- A new frame becomes displayable no earlier than the edge ending the last bar of the current screen. The maximum wait is one full LCD frame.
- Write throughput: 1 bin/cycle with no backpressure; consecutive fft_last pulses are legal.
- frame_drop: registered, 1 cycle wide, asserted on the edge after the offending fft_last.

## Test plan
- Reset:
  - Stimulus: assert sys_rst_n=0 mid-stream, release, pulse data_req for line 0.
  - Required: line_cnt=0, line_length=0, frame_drop=0; after the request, line_length=0.
- Frame load and swap:
  - Stimulus: write a 64-bin frame with bin k = k*256 (MAG_SHIFT=4). Then issue 64 data_req/wr_over pairs twice.
  - Required: the first screen shows 0. After the swap, line k reads k*16 and line_cnt wraps 63->0.
- Clamp:
  - Stimulus: a bin of 16'hFFFF with MAG_SHIFT=4.
  - Required: line_length=799. A bin of 12784 (m=799) gives 799; 12768 (m=798) gives 798.
- Overrun:
  - Stimulus: two complete frames (values 100 then 200) with no intervening screen end.
  - Required: frame_drop pulses once, and the next screen shows 200>>4=12.
- Excess bins:
  - Stimulus: a 100-bin frame.
  - Required: bins 64..99 are ignored, and the next frame starts at address 0.
- Coincidence:
  - Stimulus: fft_last in the same cycle as the final wr_over with line_cnt=63.
  - Required: swap occurs, and line 63 of the next screen shows the last bin written.
